// File: rtl/decode_stage_pipe.sv
// Instruction decode stage: register-file addressing, load-use hazard
// detection, branch resolution and the registered EX bundle.
module decode_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instruction,
    input  logic              flush,
    input  logic              ex_stall,
    output logic [2:0]        rf_raddr1,
    output logic [2:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [2:0]        decoding_op_src1,
    output logic [2:0]        decoding_op_src2,
    output logic              branch_taken,
    output logic [IMM_W-1:0]  branch_offset_imm,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_cmd,
    output logic [DATA_W-1:0] ex_alu_src1,
    output logic [DATA_W-1:0] ex_alu_src2,
    output logic              ex_mem_write_en,
    output logic [DATA_W-1:0] ex_mem_write_data,
    output logic              ex_wb_en,
    output logic [2:0]        ex_wb_dest,
    output logic              ex_wb_mux
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_SRU  = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_LD   = 4'd10;
    localparam logic [3:0] OP_ST   = 4'd11;
    localparam logic [3:0] OP_BZ   = 4'd12;
    localparam logic [3:0] OP_BNZ  = 4'd13;

    localparam logic [3:0] ALU_NC  = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;

    logic [3:0]        op;
    logic [2:0]        rd;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_sext;

    logic is_r;
    logic is_addi;
    logic is_ld;
    logic is_st;
    logic is_bz;
    logic is_bnz;
    logic use_src1;
    logic use_src2;
    logic load_use;

    logic [3:0]        d_alu_cmd;
    logic [DATA_W-1:0] d_alu_src2;
    logic              d_mem_write_en;
    logic              d_wb_en;
    logic              d_wb_mux;

    assign op       = instruction[15:12];
    assign rd       = instruction[11:9];
    assign imm      = instruction[IMM_W-1:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    assign is_r    = (op != OP_NOP) && (op <= OP_SRU);
    assign is_addi = (op == OP_ADDI);
    assign is_ld   = (op == OP_LD);
    assign is_st   = (op == OP_ST);
    assign is_bz   = (op == OP_BZ);
    assign is_bnz  = (op == OP_BNZ);

    // Opcodes 14-15 behave as NOP, so they read no sources either.
    assign use_src1 = is_r | is_addi | is_ld | is_st | is_bz | is_bnz;
    assign use_src2 = is_r | is_st;

    assign rf_raddr1        = instruction[8:6];
    assign rf_raddr2        = is_st ? instruction[11:9] : instruction[5:3];
    assign decoding_op_src1 = rf_raddr1;
    assign decoding_op_src2 = rf_raddr2;

    assign load_use = instr_valid & ex_valid & ex_wb_en & ex_wb_mux &
                      ((use_src1 & (ex_wb_dest == rf_raddr1)) |
                       (use_src2 & (ex_wb_dest == rf_raddr2)));

    assign id_stall = load_use | ex_stall;

    assign branch_taken = instr_valid & ~flush & ~id_stall &
                          ((is_bz  & (rf_rdata1 == '0)) |
                           (is_bnz & (rf_rdata1 != '0)));

    assign branch_offset_imm = imm;

    always_comb begin
        d_alu_cmd      = ALU_NC;
        d_alu_src2     = rf_rdata2;
        d_mem_write_en = 1'b0;
        d_wb_en        = 1'b0;
        d_wb_mux       = 1'b0;
        unique case (1'b1)
            is_r: begin
                d_alu_cmd = op;
                d_wb_en   = 1'b1;
            end
            is_addi, is_ld: begin
                d_alu_cmd  = ALU_ADD;
                d_alu_src2 = imm_sext;
                d_wb_en    = 1'b1;
                d_wb_mux   = is_ld;
            end
            is_st: begin
                d_alu_cmd      = ALU_ADD;
                d_alu_src2     = imm_sext;
                d_mem_write_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (!ex_stall && (!instr_valid || flush || load_use))) begin
            ex_valid          <= 1'b0;
            ex_alu_cmd        <= '0;
            ex_alu_src1       <= '0;
            ex_alu_src2       <= '0;
            ex_mem_write_en   <= 1'b0;
            ex_mem_write_data <= '0;
            ex_wb_en          <= 1'b0;
            ex_wb_dest        <= '0;
            ex_wb_mux         <= 1'b0;
        end else if (!ex_stall) begin
            ex_valid          <= 1'b1;
            ex_alu_cmd        <= d_alu_cmd;
            ex_alu_src1       <= rf_rdata1;
            ex_alu_src2       <= d_alu_src2;
            ex_mem_write_en   <= d_mem_write_en;
            ex_mem_write_data <= rf_rdata2;
            ex_wb_en          <= d_wb_en;
            ex_wb_dest        <= rd;
            ex_wb_mux         <= d_wb_mux;
        end
    end

endmodule

// File: doc/decode_stage_pipe.md
DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 Parameter: DATA_W, default 16, register and ALU datapath width; legal range 8..32.
REQ-002 Parameter: IMM_W, default 6, immediate/branch-offset width, fixed at instruction bits [5:0] for the default format.
REQ-003 Ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock, rising edge.
 rst  in  1  synchronous, active-high reset.
 instr_valid  in  1  instruction bus holds a live instruction.
 instruction  in  16  [15:12] op, [11:9] rd/st-src, [8:6] rs1, [5:3] rs2, [5:0] imm.
 flush  in  1  kill the instruction currently in decode.
 ex_stall  in  1  EX cannot accept; hold the output register.
 rf_raddr1 / rf_raddr2  out  3  register file read addresses.
 rf_rdata1 / rf_rdata2  in  DATA_W  read data, already forwarded externally.
 decoding_op_src1 / decoding_op_src2  out  3  source register numbers, to the hazard unit.
 branch_taken  out  1  redirect fetch this cycle.
 branch_offset_imm  out  IMM_W  raw branch offset to IF.
 id_stall  out  1  IF holds PC and instruction.
 ex_valid, ex_alu_cmd[3:0], ex_alu_src1[DATA_W], ex_alu_src2[DATA_W], ex_mem_write_en, ex_mem_write_data[DATA_W], ex_wb_en, ex_wb_dest[3], ex_wb_mux  out  registered EX bundle (wb_mux=1 means result from memory).

Function
REQ-004 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SL, 7 SR, 8 SRU, 9 ADDI, 10 LD, 11 ST, 12 BZ, 13 BNZ; 14-15 decode as NOP.
REQ-005 ALU cmd: NC 0, ADD 1, SUB 2, AND 3, OR 4, XOR 5, SL 6, SR 7, SRU 8.
REQ-006 rf_raddr1 = instr[8:6] always; rf_raddr2 = instr[11:9] for ST, else instr[5:3].
REQ-007 R-type (1-8): alu_src1=rdata1, alu_src2=rdata2, wb_en=1, wb_dest=rd, wb_mux=0.
REQ-008 ADDI/LD: alu ADD, alu_src2 = sign-extended imm to DATA_W; wb_en=1, wb_dest=rd; wb_mux=1 for LD only.
REQ-009 ST: alu ADD, src1=rdata1, src2=sext(imm), mem_write_en=1, mem_write_data=rdata2, wb_en=0.
REQ-010 NOP/BZ/BNZ: alu NC, wb_en=0, mem_write_en=0, ex_valid=1; mem_write_data=rdata2 in all cases.
REQ-011 Source use: src1 used by all ops except NOP; src2 used by R-type and ST only; decoding_op_src1/2 = rf_raddr1/2.
REQ-012 Load-use hazard (combinational): instr_valid & ex_valid & ex_wb_en & ex_wb_mux & ex_wb_dest equals a used source -> id_stall=1.
REQ-013 id_stall = load-use hazard OR ex_stall.
REQ-014 branch_taken = instr_valid & !flush & !id_stall & ((BZ & rdata1==0) | (BNZ & rdata1!=0)); branch_offset_imm = instr[5:0] unconditionally.
REQ-015 Output register update at each rising edge, in priority order:
 - rst: all ex_* cleared.
 - ex_stall: hold all ex_*.
 - !instr_valid, flush or load-use hazard: load bubble (all ex_* = 0).
 - otherwise: load the decoded bundle.
REQ-016 Latency: one cycle from a decoded instruction to the ex_* bundle; load-use costs exactly one bubble.
REQ-017 flush and load-use in the same cycle: bubble loaded; id_stall still follows REQ-013.

Reset
REQ-018 During rst every ex_* output reads 0 after the edge; combinational outputs track inputs throughout; no state survives rst.
REQ-019 rst asserted mid-stall or mid-hazard clears the bundle; the first post-reset cycle decodes normally.

Verification
REQ-020 Reset: rst=1 for 2 cycles with a valid ADD on the bus -> all ex_* = 0; ex_valid=0.
REQ-021 ADD r0,r1,r2 with rdata1=31, rdata2=28 -> next edge: ex_valid=1, alu_cmd=1, src1=31, src2=28, wb_en=1, wb_dest=0, wb_mux=0.
REQ-022 ST r4,31(r5) with rdata1=7, rdata2=0x9A3C -> raddr1=5, raddr2=4; src1=7, src2=0x001F, mem_write_en=1, mem_write_data=0x9A3C, wb_en=0.
REQ-023 BZ r7,-10 -> if rdata1=0: branch_taken=1, offset=6'b110110; if rdata1=3: branch_taken=0; BNZ gives the inverse; flush=1 forces 0.
REQ-024 LD r3,2(r1) then ADD r0,r3,r2 -> id_stall=1 for one cycle, ex_valid=0 for one cycle, then ADD appears with src1=rdata1.
REQ-025 ex_stall=1 for 3 cycles after ADD -> ex_* frozen at ADD values, id_stall=1, branch_taken=0; a new op loads on the first edge after release.
